// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish early.
`ifndef ALU_CONTROL_SIZE
`define ALU_CONTROL_SIZE 5
`endif
`ifndef ALU_ADD
`define ALU_ADD  5'd0
`endif
`ifndef ALU_DIV
`define ALU_DIV  5'd12
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'd13
`endif
`ifndef ALU_REM
`define ALU_REM  5'd14
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'd15
`endif

module div_unit #(
    parameter int XLEN = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [`ALU_CONTROL_SIZE-1:0] alu_control_i,
    input  logic [XLEN-1:0]              src_a_i,
    input  logic [XLEN-1:0]              src_b_i,
    input  logic                         flush_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [XLEN-1:0]              result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic            want_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    logic            is_div, is_divu, is_rem, is_remu;
    logic            is_signed, accept;
    logic            a_neg, b_neg;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic [XLEN:0]   rem_sh, diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_d, quo_d, fin_q, fin_r, fin_d;

    always_comb begin
        is_div    = (alu_control_i == `ALU_DIV);
        is_divu   = (alu_control_i == `ALU_DIVU);
        is_rem    = (alu_control_i == `ALU_REM);
        is_remu   = (alu_control_i == `ALU_REMU);
        is_signed = is_div | is_rem;
        accept    = start_i & (is_div | is_divu | is_rem | is_remu)
                  & (state_q != S_BUSY);
        a_neg     = is_signed & src_a_i[XLEN-1];
        b_neg     = is_signed & src_b_i[XLEN-1];
        abs_a     = a_neg ? (~src_a_i + 1'b1) : src_a_i;
        abs_b     = b_neg ? (~src_b_i + 1'b1) : src_b_i;
        div_zero  = (src_b_i == '0);
        ovf       = is_signed & (src_a_i == MIN_NEG) & (src_b_i == '1);
        special   = div_zero | ovf;
        if (div_zero)
            special_res = (is_div | is_divu) ? '1 : src_a_i;
        else
            special_res = is_div ? MIN_NEG : '0;
    end

    // Partial remainder < divisor, so XLEN+1 bits hold the trial difference sign.
    always_comb begin
        rem_sh = {rem_q, dvd_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_bit  = ~diff[XLEN];
        rem_d  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_d  = {quo_q[XLEN-2:0], q_bit};
        fin_q  = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
        fin_r  = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
        fin_d  = want_rem_q ? fin_r : fin_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            want_rem_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= dvd_q << 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= fin_d;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        cnt_q      <= CNT_LAST;
                        dvd_q      <= abs_a;
                        dvs_q      <= abs_b;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        want_rem_q <= is_rem | is_remu;
                        neg_quo_q  <= is_div & (a_neg ^ b_neg);
                        neg_rem_q  <= is_rem & a_neg;
                        if (special) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state_q <= S_BUSY;
                            busy_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider that executes the ALU_DIV, ALU_DIVU, ALU_REM and ALU_REMU operations selected by the ALU control decode.
- Sits in the execute stage next to the single-cycle ALU and consumes the same alu_control and operand buses.
- Multi-cycle: the hazard unit stalls the pipeline while the divider is working.
- Implements the RISC-V M-extension results, including divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request from execute stage; qualified by alu_control_i
- alu_control_i  input  `ALU_CONTROL_SIZE  decoded ALU operation (ALU_* encodings)
- src_a_i  input  XLEN  dividend
- src_b_i  input  XLEN  divisor
- flush_i  input  1  abort the in-flight operation (branch mispredict or trap)
- busy_o  output  1  high while iterating; the hazard unit stalls on it
- done_o  output  1  one-cycle pulse; result_o is valid in this cycle
- result_o  output  XLEN  quotient or remainder

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE, busy_o=0, done_o=0, result_o=0, iteration counter=0.
- States: IDLE, BUSY, DONE.
- Accept condition: start_i=1 AND alu_control_i is one of {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU} AND state is IDLE or DONE. This allows back-to-back operations.
- Ignored starts: start_i with any other alu_control_i is ignored. start_i while in BUSY is ignored, and the operands are not re-sampled.
- On accept: register the op, the operand signs, |src_a_i| and |src_b_i| (absolute values for signed ops only), and load counter=XLEN-1.
- Special cases, decided at accept, go straight to DONE next cycle (latency 1, BUSY skipped):
  - divisor==0: DIV/DIVU give all ones; REM/REMU give src_a_i.
  - DIV with src_a_i==0x8000_0000 and src_b_i==0xFFFF_FFFF: result 0x8000_0000. The matching REM gives 0.
- Normal path, BUSY: one quotient bit per cycle, MSB first.
  - Shift the partial remainder left by one and bring in the next dividend bit.
  - Trial-subtract the divisor using XLEN+1 bits. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - The counter decrements each cycle. The cycle with counter==0 moves to DONE.
- Accept-to-done latency is XLEN+1 cycles: accept at cycle 0, BUSY in cycles 1..XLEN, done_o at cycle XLEN+1.
- Sign fix, registered into result_o on entry to DONE:
  - DIV quotient is negated iff the operand signs differ.
  - REM remainder takes the sign of the dividend.
  - Unsigned ops are not corrected.
- DONE lasts one cycle with done_o=1. It goes to IDLE, or back to BUSY/DONE if a new start is accepted in that cycle.
- result_o holds its value until the next DONE entry.
- busy_o=1 exactly when state==BUSY. It is 0 in IDLE and in DONE.
- flush_i:
  - In any state, the next state is IDLE, busy_o=0 and done_o=0 next cycle.
  - flush_i has priority over start_i and over completion in the same cycle.
  - result_o keeps its old value.
- rst_i mid-operation: same as flush_i, and result_o is also cleared to 0.
- Arithmetic is modulo 2^XLEN. Absolute values use two's-complement negation, so |0x8000_0000| is handled as the unsigned value 2^31.

Test Plan:
- DIVU src_a=100, src_b=7, start at cycle 0 -> busy_o high cycles 1..32; done_o pulse at cycle 33 with result_o=14. REMU with the same operands -> 2.
- DIV src_a=0xFFFF_FFF9 (-7), src_b=2 -> result_o=0xFFFF_FFFD (-3). REM with the same operands -> 0xFFFF_FFFF (-1). DIV -7/-2 -> 3.
- DIVU 0x1234/0 -> done_o at cycle 1 with 0xFFFF_FFFF, busy_o never high. REMU 0x1234/0 -> 0x1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> done_o at cycle 1, result 0x8000_0000. REM with the same operands -> 0.
- Start DIVU 50/5, flush_i at cycle 10 -> state IDLE at cycle 11, no done_o. Then:
  - start_i with ALU_ADD -> ignored, busy_o stays 0.
  - start_i during a later BUSY with new operands -> original result returned.
- Back-to-back: second DIVU start asserted in the DONE cycle (cycle 33) -> accepted, second done_o at cycle 66. rst_i asserted at cycle 40 instead -> all outputs 0 next cycle.
